// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between the core and the test loader port
//
// Purpose:
//   Shares one single-port data RAM between the core data port and the
//   loader (test load/dump) port. Ownership is a registered state; every
//   output is combinational from the current owner and the current inputs.
//   The core is favoured on contention, and the loader is guaranteed a beat
//   once it has waited STARVE_MAX consecutive cycles.
//
// Parameters:
//   STARVE_MAX   - consecutive loader-waiting cycles (1..7) before the loader
//                  wins a contended cycle
//   STALL_W      - width of the saturating stall statistics counter
//
// Ports:
//   CLK          - clock, all state updates on the rising edge
//   reset        - asynchronous active-high reset
//   core_req/we/addr/wdata  - core data-memory request
//   core_rdata   - read data to the core (valid when core_stall=0)
//   core_stall   - core must hold PC and its request this cycle
//   ld_req/we/addr/wdata    - loader request
//   ld_rdata     - read data to the loader (valid when ld_ack=1)
//   ld_ack       - single-cycle completion strobe for the loader
//   mem_addr/wdata/we       - RAM drive (combinational read, write on CLK)
//   mem_rdata    - RAM read data
//   owner        - ownership state: 00 IDLE, 01 CORE, 10 LOAD
//   stall_cycles - saturating count of core_stall cycles

module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int STALL_W    = 16
) (
    input  logic               CLK,
    input  logic               reset,

    input  logic               core_req,
    input  logic               core_we,
    input  logic [7:0]         core_addr,
    input  logic [7:0]         core_wdata,
    output logic [7:0]         core_rdata,
    output logic               core_stall,

    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [7:0]         ld_addr,
    input  logic [7:0]         ld_wdata,
    output logic [7:0]         ld_rdata,
    output logic               ld_ack,

    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic [7:0]         mem_rdata,

    output logic [1:0]         owner,
    output logic [STALL_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_LOAD = 2'b10
    } own_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [2:0] STARVE_SAT = 3'd7;

    own_t       state;
    logic [2:0] starve_cnt;
    logic [2:0] starve_eff;
    logic       own_core;
    logic       own_load;

    assign own_core = (state == OWN_CORE);
    assign own_load = (state == OWN_LOAD);
    assign owner    = state;

    // Datapath: the owning port drives the RAM. IDLE parks the address mux on
    // the core but never writes; reset forces IDLE asynchronously, so a write
    // in flight is cancelled the instant reset rises.
    assign mem_addr   = own_load ? ld_addr  : core_addr;
    assign mem_wdata  = own_load ? ld_wdata : core_wdata;
    assign mem_we     = (own_core & core_req & core_we) |
                        (own_load & ld_req   & ld_we);

    assign core_rdata = mem_rdata;
    assign ld_rdata   = mem_rdata;

    assign core_stall = core_req & ~own_core;
    assign ld_ack     = ld_req & own_load;

    // A beat being acked this cycle has consumed the loader's starvation
    // credit. Without this, the stale counter value would hand the loader a
    // second consecutive grant under contention instead of one beat per grant.
    assign starve_eff = ld_ack ? 3'd0 : starve_cnt;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= OWN_IDLE;
            starve_cnt   <= 3'd0;
            stall_cycles <= '0;
        end else begin
            // Ownership: core wins contention unless the loader is starving;
            // with no request at all the arbiter parks on the core.
            if (core_req && ld_req) begin
                state <= (starve_eff >= STARVE_LIM) ? OWN_LOAD : OWN_CORE;
            end else if (ld_req) begin
                state <= OWN_LOAD;
            end else begin
                state <= OWN_CORE;
            end

            // Starvation counter: counts waiting cycles, saturates at 7.
            if (!ld_req || ld_ack) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt != STARVE_SAT) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            // Stall statistics: saturate instead of wrapping.
            if (core_stall && (stall_cycles != {STALL_W{1'b1}})) begin
                stall_cycles <= stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [7:0]  core_addr, core_wdata;
    logic [7:0]  core_rdata;
    logic        core_stall;
    logic        ld_req, ld_we;
    logic [7:0]  ld_addr, ld_wdata;
    logic [7:0]  ld_rdata;
    logic        ld_ack;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;
    logic [15:0] stall_cycles;

    // Narrow-counter instance sharing the same stimulus, for saturation.
    logic [7:0]  s_core_rdata, s_ld_rdata, s_mem_addr, s_mem_wdata;
    logic        s_core_stall, s_ld_ack, s_mem_we;
    logic [1:0]  s_owner;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:255];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end
    assign mem_rdata = ram[mem_addr];

    dmem_arbiter #(.STARVE_MAX(4), .STALL_W(16)) dut (
        .CLK(CLK), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner), .stall_cycles(stall_cycles)
    );

    dmem_arbiter #(.STARVE_MAX(4), .STALL_W(4)) dut_s (
        .CLK(CLK), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(s_core_rdata), .core_stall(s_core_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(s_ld_rdata), .ld_ack(s_ld_ack),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
        .mem_rdata(mem_rdata), .owner(s_owner), .stall_cycles(s_stall_cycles)
    );

    task preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task test_reset;
        @(negedge CLK);
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10;
        ld_req = 1'b1; ld_we = 1'b1;
        #1;
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %h exp %h", owner, 2'b00); end
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL reset_core_stall got %b exp 1", core_stall); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ld_ack got %b exp 0", ld_ack); end
        @(negedge CLK); #1;
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    endtask

    task test_core_read;
        @(negedge CLK);
        reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        ld_req = 1'b0; ld_we = 1'b0;
        #1;
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL cr_c0_stall got %b exp 1", core_stall); end
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL cr_c0_owner got %h exp 0", owner); end
        @(negedge CLK); #1;
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL cr_c1_owner got %h exp 1", owner); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cr_c1_stall got %b exp 0", core_stall); end
        checks++; if (core_rdata !== 8'h5A) begin errors++; $display("FAIL cr_rdata got %h exp 5a", core_rdata); end
        checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL cr_stall_cycles got %0d exp 1", stall_cycles); end
    endtask

    task test_load_write;
        @(negedge CLK);
        core_req = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h33;
        #1;
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL lw_c0_owner got %h exp 1", owner); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL lw_c0_ack got %b exp 0", ld_ack); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lw_c0_we got %b exp 0", mem_we); end
        @(negedge CLK); #1;
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL lw_c1_owner got %h exp 2", owner); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL lw_c1_we got %b exp 1", mem_we); end
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL lw_c1_ack got %b exp 1", ld_ack); end
        checks++; if (mem_addr !== 8'h20) begin errors++; $display("FAIL lw_c1_addr got %h exp 20", mem_addr); end
        checks++; if (mem_wdata !== 8'h33) begin errors++; $display("FAIL lw_c1_wdata got %h exp 33", mem_wdata); end
        // Loader withdraws while still owning: no access, no ack.
        @(negedge CLK);
        ld_req = 1'b0; ld_wdata = 8'hEE;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
        #1;
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL ld_drop_owner got %h exp 2", owner); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ld_drop_we got %b exp 0", mem_we); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL ld_drop_ack got %b exp 0", ld_ack); end
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL ld_drop_stall got %b exp 1", core_stall); end
        @(negedge CLK); #1;
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL ld_drop_next_owner got %h exp 1", owner); end
        checks++; if (core_rdata !== 8'h33) begin errors++; $display("FAIL lw_readback got %h exp 33", core_rdata); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL lw_readback_stall got %b exp 0", core_stall); end
        checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", stall_cycles); end
        ld_we = 1'b0;
    endtask

    task test_contention;
        logic       is_ld;
        logic [1:0] exp_owner;
        int         exp_stall;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
            ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
            #1;
            is_ld     = ((i % 6) == 5);
            exp_owner = is_ld ? 2'b10 : 2'b01;
            exp_stall = (i > 5) ? 3 : 2;
            checks++; if (owner !== exp_owner) begin errors++; $display("FAIL cont_owner[%0d] got %h exp %h", i, owner, exp_owner); end
            checks++; if (core_stall !== is_ld) begin errors++; $display("FAIL cont_stall[%0d] got %b exp %b", i, core_stall, is_ld); end
            checks++; if (ld_ack !== is_ld) begin errors++; $display("FAIL cont_ack[%0d] got %b exp %b", i, ld_ack, is_ld); end
            checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL cont_stall_cycles[%0d] got %0d exp %0d", i, stall_cycles, exp_stall); end
            if (is_ld) begin
                checks++; if (ld_rdata !== 8'h33) begin errors++; $display("FAIL cont_ld_rdata[%0d] got %h exp 33", i, ld_rdata); end
            end else begin
                checks++; if (core_rdata !== 8'h5A) begin errors++; $display("FAIL cont_core_rdata[%0d] got %h exp 5a", i, core_rdata); end
            end
        end
    endtask

    task test_back_to_back;
        @(negedge CLK);
        core_req = 1'b0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
        @(negedge CLK);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h60;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h60; ld_wdata = 8'hA5;
        #1;
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL b2b_owner got %h exp 2", owner); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL b2b_we got %b exp 1", mem_we); end
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", core_stall); end
        @(negedge CLK);
        ld_req = 1'b0; ld_we = 1'b0;
        #1;
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL b2b_next_owner got %h exp 1", owner); end
        checks++; if (core_rdata !== 8'hA5) begin errors++; $display("FAIL b2b_rdata got %h exp a5", core_rdata); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL b2b_next_stall got %b exp 0", core_stall); end
    endtask

    task test_reset_mid_write;
        @(negedge CLK);
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h99;
        ld_req = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmw_pre_we got %b exp 1", mem_we); end
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we got %b exp 0", mem_we); end
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rmw_owner got %h exp 0", owner); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rmw_stall_cycles got %0d exp 0", stall_cycles); end
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rmw_core_stall got %b exp 1", core_stall); end
        #1 reset = 1'b0;
        core_req = 1'b0; core_we = 1'b0;
        @(negedge CLK);
        core_req = 1'b1; core_addr = 8'h40;
        #1;
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rmw_release_owner got %h exp 1", owner); end
        checks++; if (core_rdata !== 8'hC3) begin errors++; $display("FAIL rmw_ram_40 got %h exp c3", core_rdata); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rmw_release_stall_cycles got %0d exp 0", stall_cycles); end
    endtask

    task test_stall_saturate;
        @(negedge CLK);
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        // Two-cycle pattern: loader alone takes ownership, then the core
        // requests while the loader owns, giving one stall per pair.
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            core_req = 1'b0; ld_req = 1'b1;
            @(negedge CLK);
            core_req = 1'b1; ld_req = 1'b1;
            #1;
            checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d] got %b exp 1", k, core_stall); end
            if (k == 16) begin
                checks++; if (s_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_narrow_15 got %0d exp 15", s_stall_cycles); end
            end
        end
        @(negedge CLK);
        core_req = 1'b0; ld_req = 1'b0;
        #1;
        checks++; if (s_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_narrow_hold got %h exp f", s_stall_cycles); end
        checks++; if (stall_cycles !== 16'd19) begin errors++; $display("FAIL sat_wide_count got %0d exp 19", stall_cycles); end
    endtask

    initial begin
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;
        pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
        preload(8'h10, 8'h5A);
        preload(8'h40, 8'hC3);
        test_reset;
        test_core_read;
        test_load_write;
        test_contention;
        test_back_to_back;
        test_reset_mid_write;
        test_stall_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL be the number of consecutive loader-waiting cycles (1..7) after which the loader wins a contended cycle.
REQ-002 Parameter STALL_W, default 16, SHALL be the width of the stall statistics counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high; asserting it forces the reset state immediately, independent of CLK.
REQ-005 core_req / core_we  input  1 / 1  SHALL be the core data-memory request and write enable.
REQ-006 core_addr / core_wdata  input  8 / 8  SHALL be the core address and write data.
REQ-007 core_rdata  output  8  SHALL be the read data returned to the core.
REQ-008 core_stall  output  1  SHALL tell the core to hold PC and request this cycle.
REQ-009 ld_req / ld_we  input  1 / 1  SHALL be the loader (test load/dump port) request and write enable.
REQ-010 ld_addr / ld_wdata  input  8 / 8  SHALL be the loader address and write data.
REQ-011 ld_rdata / ld_ack  output  8 / 1  SHALL be the loader read data and single-cycle completion strobe.
REQ-012 mem_addr / mem_wdata / mem_we  output  8 / 8 / 1  SHALL drive the data RAM (combinational read, write on CLK rising edge).
REQ-013 mem_rdata  input  8  SHALL be the data RAM read data.
REQ-014 owner  output  2  SHALL expose the ownership state: 00 IDLE, 01 CORE, 10 LOAD.
REQ-015 stall_cycles  output  STALL_W  SHALL count cycles with core_stall=1.

Function
REQ-016 Ownership SHALL be a registered state {IDLE, CORE, LOAD}; all outputs are combinational from owner and current inputs.
REQ-017 Next owner at each edge SHALL be: both requests with starve_cnt >= STARVE_MAX -> LOAD; both requests otherwise -> CORE; ld_req only -> LOAD; otherwise CORE (park on CORE).
REQ-018 An access SHALL complete in any cycle where the owner matches an asserted request; the loader gets exactly one beat per LOAD grant, then re-arbitration.
REQ-019 mem_addr/mem_wdata SHALL mux from the owning port; mem_we = core_we&core_req when owner=CORE, ld_we&ld_req when owner=LOAD, else 0.
REQ-020 core_rdata and ld_rdata SHALL both equal mem_rdata; validity is signalled only by ~core_stall and ld_ack respectively.
REQ-021 core_stall SHALL be core_req & (owner != CORE); it SHALL be 0 whenever core_req=0.
REQ-022 ld_ack SHALL be ld_req & (owner == LOAD) and SHALL NOT assert for a request withdrawn before its grant cycle.
REQ-023 starve_cnt (3 bits, internal) SHALL increment, saturating at 7, each cycle ld_req=1 and ld_ack=0, and SHALL clear to 0 on any ld_ack cycle or when ld_req=0.
REQ-024 stall_cycles SHALL increment on each core_stall cycle and saturate at all-ones.
REQ-025 Owner LOAD with ld_req dropped SHALL perform no access (mem_we=0) and re-arbitrate at the next edge.
REQ-026 A write and read of the same address in consecutive cycles by different ports SHALL see the written value (RAM write-then-read ordering).

Reset
REQ-027 While reset=1: owner=IDLE, starve_cnt=0, stall_cycles=0, mem_we=0, ld_ack=0, core_stall=core_req.
REQ-028 Reset asserted mid-access SHALL cancel the access at once (mem_we=0 combinationally); no partial write retries after release.
REQ-029 First edge after reset release SHALL apply REQ-017 from IDLE.

Verification
REQ-030 Reset release, core_req=1 read addr 0x10 (RAM 0x10=0x5A) -> cycle 0 core_stall=1, owner IDLE; cycle 1 owner=CORE, core_stall=0, core_rdata=0x5A; stall_cycles=1.
REQ-031 ld_req only, write 0x33 to 0x20 -> next cycle owner=LOAD, mem_we=1, ld_ack=1; core read of 0x20 afterwards returns 0x33.
REQ-032 core_req and ld_req held continuously, STARVE_MAX=4 -> core served 5 cycles, loader acked on cycle 6, starve_cnt back to 0, pattern repeats; core_stall=1 only on loader cycles.
REQ-033 Owner=LOAD, ld_req dropped -> mem_we=0, ld_ack=0, owner=CORE next edge.
REQ-034 reset pulsed (between edges) during a core write to 0x40 -> mem_we falls immediately, owner=IDLE, RAM 0x40 unchanged, counters 0.
REQ-035 Force 2^STALL_W+3 stall cycles -> stall_cycles holds at 0xFFFF, no wrap.
